// File: rtl/dmem_responder_pkg.sv
// Shared types and defaults for the byte-wide data memory responder.
// Holds the FSM encoding, counter width and the address range check.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int DEFAULT_DEPTH       = 256;
  localparam int DEFAULT_WAIT_CYCLES = 2;
  localparam int CNT_W               = 4;

  // Full 32-bit compare so high address bits can never alias into the array.
  function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response handshake bundle between a load/store initiator and
// the data memory responder.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic        busy;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );
endinterface

// File: rtl/dmem_byte_array.sv
// Byte storage: synchronous write, combinational read, asynchronous clear.
// Shares one address port between read and write.
module dmem_byte_array #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [7:0]    i_wdata,
  output logic [7:0]    o_rdata
);

  logic [7:0] r_mem [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 8'h00;
      end
    end else if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding byte load/store responder with a fixed number of
// wait states between request accept and response.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH       = DEFAULT_DEPTH,
  parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
  input  logic           clk,
  input  logic           reset,
  dmem_responder_if.slave bus
);

  localparam int               AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic             ZERO_WAIT = (WAIT_CYCLES == 0);
  localparam logic [CNT_W-1:0] WAIT_LOAD = ZERO_WAIT ? '0 : CNT_W'(WAIT_CYCLES - 1);

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_write;
  logic             r_in_range;
  logic [AW-1:0]    r_idx;
  logic [7:0]       r_wdata;
  logic             r_req_ready;
  logic             r_rsp_valid;
  logic [7:0]       r_rsp_rdata;
  logic             r_rsp_err;
  logic             r_busy;

  logic             w_accept;
  logic             w_req_in_range;
  logic             w_wait_done;
  logic             w_enter_resp;
  logic             w_sel_write;
  logic             w_sel_in_range;
  logic [AW-1:0]    w_sel_idx;
  logic [7:0]       w_sel_wdata;
  logic             w_we;
  logic [7:0]       w_mem_rdata;
  logic [7:0]       w_rsp_rdata;

  assign w_req_in_range = addr_in_range(bus.req_addr, DEPTH);
  assign w_accept       = bus.req_valid & r_req_ready;
  assign w_wait_done    = (r_state == WAIT) && (r_cnt == '0);
  assign w_enter_resp   = (w_accept && ZERO_WAIT) || w_wait_done;

  // With no wait states RESP is entered straight from the accept edge, so the
  // live request fields are used; otherwise the latched copy is.
  assign w_sel_write    = w_wait_done ? r_write    : bus.req_write;
  assign w_sel_in_range = w_wait_done ? r_in_range : w_req_in_range;
  assign w_sel_idx      = w_wait_done ? r_idx      : bus.req_addr[AW-1:0];
  assign w_sel_wdata    = w_wait_done ? r_wdata    : bus.req_wdata;

  assign w_we        = w_enter_resp & w_sel_write & w_sel_in_range;
  assign w_rsp_rdata = (w_sel_in_range && !w_sel_write) ? w_mem_rdata : 8'h00;

  dmem_byte_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk     (clk),
    .reset   (reset),
    .i_we    (w_we),
    .i_addr  (w_sel_idx),
    .i_wdata (w_sel_wdata),
    .o_rdata (w_mem_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_write     <= 1'b0;
      r_in_range  <= 1'b0;
      r_idx       <= '0;
      r_wdata     <= 8'h00;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 8'h00;
      r_rsp_err   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_write     <= bus.req_write;
            r_in_range  <= w_req_in_range;
            r_idx       <= bus.req_addr[AW-1:0];
            r_wdata     <= bus.req_wdata;
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
            if (ZERO_WAIT) begin
              r_state     <= RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_rdata <= w_rsp_rdata;
              r_rsp_err   <= !w_sel_in_range;
            end else begin
              r_state <= WAIT;
              r_cnt   <= WAIT_LOAD;
            end
          end else begin
            // First edge after reset release raises ready here.
            r_req_ready <= 1'b1;
          end
        end
        WAIT: begin
          if (r_cnt == '0) begin
            r_state     <= RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= w_rsp_rdata;
            r_rsp_err   <= !w_sel_in_range;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            r_state     <= IDLE;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 8'h00;
            r_rsp_err   <= 1'b0;
            r_busy      <= 1'b0;
            r_req_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_cnt       <= '0;
          r_rsp_valid <= 1'b0;
          r_rsp_rdata <= 8'h00;
          r_rsp_err   <= 1'b0;
          r_busy      <= 1'b0;
          r_req_ready <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = r_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.busy      = r_busy;

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH, default 256: number of byte locations held.
REQ-002 Parameter WAIT_CYCLES, default 2: wait states between request accept and response, legal range 0..15.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; 0 resets immediately, release sampled on clk.
REQ-005 req_valid  input  1  initiator presents a load/store request.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_write  input  1  1 = store byte, 0 = load byte.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  8  store data.
REQ-010 rsp_valid  output  1  response available.
REQ-011 rsp_ready  input  1  initiator takes the response this cycle.
REQ-012 rsp_rdata  output  8  load data; 0 for stores and errors.
REQ-013 rsp_err  output  1  address out of range (req_addr >= DEPTH); feeds the core's cause logic.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 The FSM SHALL have three states: IDLE, WAIT, RESP.
REQ-016 req_ready SHALL be 1 only in IDLE; rsp_valid SHALL be 1 only in RESP.
REQ-017 Accept occurs on a rising edge with req_valid=1 and req_ready=1; req_write, req_addr and req_wdata SHALL be latched at that edge.
REQ-018 On accept, with WAIT_CYCLES=0 the FSM SHALL go IDLE->RESP; otherwise IDLE->WAIT with the wait counter loaded to WAIT_CYCLES-1.
REQ-019 In WAIT the counter SHALL decrement each cycle; at count 0 the FSM SHALL go WAIT->RESP.
REQ-020 rsp_valid SHALL first assert exactly WAIT_CYCLES+1 cycles after the accept edge.
REQ-021 A store to an in-range address SHALL update the array on the edge that enters RESP, and not earlier.
REQ-022 A load SHALL present the byte at the latched address on rsp_rdata throughout RESP; a load issued after a store to the same address SHALL return the stored byte.
REQ-023 An out-of-range request SHALL leave the array unchanged, drive rsp_err=1 and rsp_rdata=0.
REQ-024 Only bits [log2(DEPTH)-1:0] SHALL index the array; the range check SHALL use the full 32-bit address, with no wrap-around.
REQ-025 rsp_valid, rsp_rdata and rsp_err SHALL stay stable in RESP until rsp_ready=1; that edge SHALL return the FSM to IDLE.
REQ-026 There is no request pipelining: a request arriving while busy=1 SHALL NOT be accepted, and the next accept SHALL be no earlier than the cycle after the response handshake.
REQ-027 rsp_ready=1 outside RESP SHALL have no effect; req_valid may drop before accept without side effects.

Reset
REQ-028 While reset=0: state=IDLE, counter=0, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, and all array bytes=0.
REQ-029 req_ready SHALL rise on the first clk edge after reset is released.
REQ-030 A reset asserted during WAIT or RESP SHALL abandon the transaction; no store commits, and no response appears after release.

Structure
REQ-031 A shared package SHALL hold the state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2), the DEPTH and WAIT_CYCLES defaults, and the counter width (4).
REQ-032 The storage SHALL be one sub-module, dmem_byte_array: synchronous write, combinational read, asynchronous clear.

Verification
REQ-033 Reset release, then store 0xA5 @0x10 and load @0x10 (WAIT_CYCLES=2, rsp_ready=1) -> each rsp_valid appears 3 cycles after accept; load returns rsp_rdata=0xA5, rsp_err=0.
REQ-034 Load @0x0000_0100 (DEPTH=256) -> rsp_err=1, rsp_rdata=0; a following load @0x00 returns 0x00, confirming no alias write.
REQ-035 Hold rsp_ready=0 for 5 cycles in RESP while req_valid=1 -> outputs stable, req_ready=0, no second accept until 1 cycle after the handshake.
REQ-036 Store 0x3C @0x20, assert reset during WAIT, release, load @0x20 -> rsp_rdata=0x00 and no stray rsp_valid after release.
REQ-037 WAIT_CYCLES=0 instance, back-to-back requests -> rsp_valid 1 cycle after each accept; accepts spaced 2 cycles apart with rsp_ready tied 1.
